vector_register_controller: RTL and testbench

VECTOR_REGISTER_CONTROLLER -- requirements
Module: vector_register_controller

---
 rtl/vector_register_pkg.sv | 8 +
 rtl/round_robin_arbiter.sv | 34 +++
 rtl/vector_register_controller.sv | 85 ++++++++
 tb/tb_vector_register_controller.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/vector_register_pkg.sv
// vector_register_pkg: shared defaults and address type for the vector register controller
package vector_register_pkg;
  localparam int DEFAULT_NUMBER_REGISTERS = 32;
  localparam int DEFAULT_REGISTER_LENGTH = 64;
  localparam int DEFAULT_NUMBER_WRITERS = 3;
  localparam int DEFAULT_AW = $clog2(DEFAULT_NUMBER_REGISTERS);
  typedef logic [DEFAULT_AW-1:0] register_address_t;
endpackage

// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter: one-hot grant to the first request at or after an internal rotating pointer
module round_robin_arbiter
  import vector_register_pkg::*;
#(
  parameter int N = DEFAULT_NUMBER_WRITERS
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] request,
  output logic [N-1:0] grant
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] pointer;
  logic [PW-1:0] grant_index;
  logic [PW-1:0] idx;
  // descending scan so the closest request to the pointer is the last to win
  always_comb begin
    grant = '0;
    grant_index = pointer;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PW'((int'(pointer) + k) % N);
      if (request[idx]) begin
        grant = '0;
        grant[idx] = 1'b1;
        grant_index = idx;
      end
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) pointer <= '0;
    else if (|grant) pointer <= grant_index == PW'(N - 1) ? '0 : grant_index + 1'b1;
  end
endmodule

// File: rtl/vector_register_controller.sv
// vector_register_controller: scoreboarded issue gating plus round-robin writeback into a vector register file
module vector_register_controller
  import vector_register_pkg::*;
#(
  parameter int NUMBER_REGISTERS = DEFAULT_NUMBER_REGISTERS,
  parameter int REGISTER_LENGTH = DEFAULT_REGISTER_LENGTH,
  parameter int NUMBER_WRITERS = DEFAULT_NUMBER_WRITERS,
  localparam int AW = $clog2(NUMBER_REGISTERS)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 issue_valid,
  output logic                                 issue_ready,
  input  logic [AW-1:0]                        issue_destination,
  input  logic [AW-1:0]                        issue_source_0,
  input  logic [AW-1:0]                        issue_source_1,
  input  logic [AW-1:0]                        issue_source_2,
  output logic                                 read_enable,
  output logic [AW-1:0]                        read_address_0,
  output logic [AW-1:0]                        read_address_1,
  output logic [AW-1:0]                        read_address_2,
  input  logic [NUMBER_WRITERS-1:0]            writeback_valid,
  input  logic [NUMBER_WRITERS*AW-1:0]         writeback_address,
  input  logic [NUMBER_WRITERS*REGISTER_LENGTH-1:0] writeback_data,
  output logic [NUMBER_WRITERS-1:0]            writeback_ready,
  output logic                                 write_enable,
  output logic [AW-1:0]                        write_address,
  output logic [REGISTER_LENGTH-1:0]           write_port,
  output logic [NUMBER_REGISTERS-1:0]          busy_vector,
  output logic                                 error_flag
);
  logic accept;
  logic granted;
  logic [AW-1:0] sel_address;
  logic [REGISTER_LENGTH-1:0] sel_data;
  logic [NUMBER_REGISTERS-1:0] busy_next;
  assign issue_ready = ~(busy_vector[issue_destination] | busy_vector[issue_source_0] |
                         busy_vector[issue_source_1] | busy_vector[issue_source_2]);
  assign accept = issue_valid & issue_ready;
  assign granted = |writeback_ready;
  round_robin_arbiter #(.N(NUMBER_WRITERS)) arbiter (
    .clock  (clock),
    .reset  (reset),
    .request(writeback_valid),
    .grant  (writeback_ready)
  );
  always_comb begin
    sel_address = '0;
    sel_data = '0;
    for (int i = 0; i < NUMBER_WRITERS; i++)
      if (writeback_ready[i]) begin
        sel_address = writeback_address[i*AW +: AW];
        sel_data = writeback_data[i*REGISTER_LENGTH +: REGISTER_LENGTH];
      end
  end
  // set is applied after clear so a same-cycle issue keeps the register reserved
  always_comb begin
    busy_next = busy_vector;
    if (granted) busy_next[sel_address] = 1'b0;
    if (accept) busy_next[issue_destination] = 1'b1;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_vector <= '0;
      read_enable <= 1'b0;
      read_address_0 <= '0;
      read_address_1 <= '0;
      read_address_2 <= '0;
      write_enable <= 1'b0;
      write_address <= '0;
      write_port <= '0;
      error_flag <= 1'b0;
    end else begin
      busy_vector <= busy_next;
      read_enable <= accept;
      read_address_0 <= accept ? issue_source_0 : read_address_0;
      read_address_1 <= accept ? issue_source_1 : read_address_1;
      read_address_2 <= accept ? issue_source_2 : read_address_2;
      write_enable <= granted;
      write_address <= granted ? sel_address : write_address;
      write_port <= granted ? sel_data : write_port;
      error_flag <= error_flag | (granted & ~busy_vector[sel_address]);
    end
  end
endmodule

// File: tb/tb_vector_register_controller.sv
// tb_vector_register_controller: directed scenarios plus randomized traffic against a behavioural scoreboard model
module tb_vector_register_controller;
  import vector_register_pkg::*;
  localparam int NR = 32;
  localparam int RL = 64;
  localparam int NW = 3;
  localparam int AW = 5;
  logic clock = 1'b0;
  logic reset;
  logic issue_valid;
  logic issue_ready;
  register_address_t issue_destination, issue_source_0, issue_source_1, issue_source_2;
  logic read_enable;
  logic [AW-1:0] read_address_0, read_address_1, read_address_2;
  logic [NW-1:0] writeback_valid;
  logic [NW*AW-1:0] writeback_address;
  logic [NW*RL-1:0] writeback_data;
  logic [NW-1:0] writeback_ready;
  logic write_enable;
  logic [AW-1:0] write_address;
  logic [RL-1:0] write_port;
  logic [NR-1:0] busy_vector;
  logic error_flag;
  register_address_t wa[NW];
  logic [RL-1:0] wd[NW];
  bit m_busy[NR];
  int m_ptr;
  bit m_err, m_re, m_we;
  logic [AW-1:0] m_ra[3];
  logic [AW-1:0] m_wa;
  logic [RL-1:0] m_wd;
  int n_assert = 0;
  int n_fail = 0;
  int g;
  always #5 clock = ~clock;
  always_comb begin
    writeback_address = '0;
    writeback_data = '0;
    for (int i = 0; i < NW; i++) begin
      writeback_address[i*AW +: AW] = wa[i];
      writeback_data[i*RL +: RL] = wd[i];
    end
  end
  vector_register_controller dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_destination(issue_destination), .issue_source_0(issue_source_0),
    .issue_source_1(issue_source_1), .issue_source_2(issue_source_2),
    .read_enable(read_enable), .read_address_0(read_address_0),
    .read_address_1(read_address_1), .read_address_2(read_address_2),
    .writeback_valid(writeback_valid), .writeback_address(writeback_address),
    .writeback_data(writeback_data), .writeback_ready(writeback_ready),
    .write_enable(write_enable), .write_address(write_address), .write_port(write_port),
    .busy_vector(busy_vector), .error_flag(error_flag)
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    foreach (m_busy[r]) m_busy[r] = 0;
    m_ptr = 0; m_err = 0; m_re = 0; m_we = 0;
    m_ra[0] = '0; m_ra[1] = '0; m_ra[2] = '0; m_wa = '0; m_wd = '0;
  endtask
  task automatic issue(input bit v, input int d, input int s0, input int s1, input int s2);
    issue_valid = v;
    issue_destination = AW'(d); issue_source_0 = AW'(s0);
    issue_source_1 = AW'(s1); issue_source_2 = AW'(s2);
  endtask
  task automatic wb(input int i, input bit v, input int a, input logic [RL-1:0] d);
    writeback_valid[i] = v; wa[i] = AW'(a); wd[i] = d;
  endtask
  task automatic check_reset_outputs();
    chk("rst_busy", busy_vector, 0);
    chk("rst_read_enable", read_enable, 0);
    chk("rst_read_addr", {read_address_0, read_address_1, read_address_2}, 0);
    chk("rst_write_enable", write_enable, 0);
    chk("rst_write_address", write_address, 0);
    chk("rst_write_port", write_port, 0);
    chk("rst_error", error_flag, 0);
    chk("rst_issue_ready", issue_ready, 1);
  endtask
  // reset asserted mid-cycle, held across one rising edge, released just after it
  task automatic pulse_reset();
    issue_valid = 0;
    writeback_valid = '0;
    reset = 1;
    #1;
    check_reset_outputs();
    model_reset();
    @(posedge clock); #1;
    reset = 0;
  endtask
  // one clock: check combinational handshakes, advance the model, then check registered state
  task automatic cycle(output int gi);
    bit rdy;
    logic [NR-1:0] eb;
    logic [NW-1:0] eg;
    #1;
    rdy = !(m_busy[issue_destination] || m_busy[issue_source_0] ||
            m_busy[issue_source_1] || m_busy[issue_source_2]);
    gi = -1;
    for (int k = 0; k < NW; k++)
      if (gi < 0 && writeback_valid[(m_ptr + k) % NW]) gi = (m_ptr + k) % NW;
    eg = '0;
    if (gi >= 0) eg[gi] = 1'b1;
    chk("issue_ready", issue_ready, rdy);
    chk("writeback_ready", writeback_ready, eg);
    m_re = issue_valid && rdy;
    if (m_re) begin
      m_ra[0] = issue_source_0; m_ra[1] = issue_source_1; m_ra[2] = issue_source_2;
    end
    m_we = gi >= 0;
    if (m_we) begin
      m_wa = wa[gi]; m_wd = wd[gi];
      if (!m_busy[wa[gi]]) m_err = 1;
      m_busy[wa[gi]] = 0;
      m_ptr = (gi + 1) % NW;
    end
    if (m_re) m_busy[issue_destination] = 1;
    @(posedge clock); #1;
    foreach (m_busy[r]) eb[r] = m_busy[r];
    chk("busy_vector", busy_vector, eb);
    chk("read_enable", read_enable, m_re);
    chk("read_addresses", {read_address_0, read_address_1, read_address_2}, {m_ra[0], m_ra[1], m_ra[2]});
    chk("write_enable", write_enable, m_we);
    chk("write_address", write_address, m_wa);
    chk("write_port", write_port, m_wd);
    chk("error_flag", error_flag, m_err);
  endtask
  initial begin
    reset = 1;
    issue(0, 0, 0, 0, 0);
    for (int i = 0; i < NW; i++) wb(i, 0, 0, '0);
    model_reset();
    #3;
    check_reset_outputs();
    @(posedge clock); @(posedge clock); #1;
    reset = 0;
    // first issue after reset
    issue(1, 5, 1, 2, 3);
    #1 chk("d1_ready", issue_ready, 1);
    cycle(g);
    chk("d1_busy", busy_vector, 32'h20);
    chk("d1_read_enable", read_enable, 1);
    chk("d1_read_addr", {read_address_0, read_address_1, read_address_2}, {5'd1, 5'd2, 5'd3});
    // hazard on busy source, cleared by writer 1, accepted one cycle later
    issue(1, 8, 5, 0, 0);
    wb(1, 1, 5, 64'hDEAD_BEEF_0000_0005);
    #1 chk("d2_blocked", issue_ready, 0);
    cycle(g);
    chk("d2_write_enable", write_enable, 1);
    chk("d2_write_address", write_address, 5);
    chk("d2_busy5", busy_vector[5], 0);
    chk("d2_read_enable", read_enable, 0);
    wb(1, 0, 0, '0);
    cycle(g);
    chk("d2_accept", read_enable, 1);
    chk("d2_busy8", busy_vector[8], 1);
    issue(0, 0, 0, 0, 0);
    pulse_reset();
    // round-robin rotation with all writers requesting
    for (int i = 0; i < NW; i++) wb(i, 1, 10 + i, {$urandom, $urandom});
    for (int k = 0; k < 6; k++) begin
      #1 chk("d3_grant", writeback_ready, 3'b001 << (k % 3));
      cycle(g);
    end
    for (int i = 0; i < NW; i++) wb(i, 0, 0, '0);
    pulse_reset();
    // writeback to a non-busy register sets the sticky error
    wb(0, 1, 9, 64'h0123_4567_89AB_CDEF);
    cycle(g);
    chk("d4_write_enable", write_enable, 1);
    chk("d4_write_port", write_port, 64'h0123_4567_89AB_CDEF);
    chk("d4_error", error_flag, 1);
    wb(0, 0, 0, '0);
    for (int k = 0; k < 3; k++) begin
      cycle(g);
      chk("d4_sticky", error_flag, 1);
    end
    pulse_reset();
    // same-cycle set and clear on register 7
    issue(1, 7, 0, 0, 0);
    wb(2, 1, 7, 64'h7);
    cycle(g);
    chk("d5_busy7", busy_vector[7], 1);
    wb(2, 0, 0, '0);
    // reset with registers 4 and 6 busy
    issue(1, 4, 0, 0, 0);
    cycle(g);
    issue(1, 6, 0, 0, 0);
    cycle(g);
    chk("d6_pre_busy", busy_vector & 32'h50, 32'h50);
    pulse_reset();
    issue(1, 4, 0, 0, 0);
    #1 chk("d6_ready", issue_ready, 1);
    cycle(g);
    chk("d6_busy", busy_vector, 32'h10);
    // randomized traffic; ungranted writers hold their request
    issue(0, 0, 0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      issue($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 7));
      for (int i = 0; i < NW; i++)
        if (!writeback_valid[i] && $urandom_range(0, 2) == 0)
          wb(i, 1, $urandom_range(0, 7), {$urandom, $urandom});
      if ($urandom_range(0, 99) == 0) pulse_reset();
      else begin
        cycle(g);
        if (g >= 0) writeback_valid[g] = 1'b0;
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
